lane_block_tracker: RTL
=======================

Name: lane_block_tracker

Overview:
- Multi-slot falling-block tracker for one piano lane.
- Spawns a block at the top on qualifying beats, advances every live block at a level-dependent speed, and retires blocks on a key hit inside the hit window or on reaching the bottom (miss).
- Generalises the single-height lane block: it adds N concurrent blocks, per-level speed, hit/miss scoring and overflow detection.
- Sits between the beat counter / pattern decoder and the VGA renderer and score logic; clocked by the frame-tick clock (clk_beat_ten domain).

Parameters:
- NUM_SLOTS, 4, number of concurrent blocks tracked.
- H_W, 10, height width in pixels.
- BEAT_W, 7, beat counter width.
- TOP, 120, spawn height.
- BOTTOM, 720, miss height; also the value reported by idle slots.
- HIT_LO, 600, lowest height accepted for a hit (inclusive).
- HIT_HI, 680, highest height accepted for a hit (inclusive).

Ports:
- clk  in  1  tick clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- restart  in  1  synchronous clear to the reset state.
- stop_or_endgame  in  1  freeze: no motion, spawn, hit or miss.
- level  in  2  speed select.
- beat_cnt  in  BEAT_W  current beat number.
- spawn_req  in  1  the current beat_cnt is a spawn beat for this lane (decoded externally).
- key_press  in  1  one-cycle key strobe for this lane.
- block_h  out  NUM_SLOTS*H_W  slot i height at bits [i*H_W +: H_W].
- block_valid  out  NUM_SLOTS  slot i is live.
- hit_pulse  out  1  one-cycle pulse: a block was hit.
- miss_pulse  out  1  one-cycle pulse: one or more blocks reached BOTTOM.
- overflow_pulse  out  1  one-cycle pulse: spawn dropped because all slots were busy.

Behaviour:
- Reset (rst=1, asynchronous) and restart (sampled on clk):
  - all block_valid=0; all block_h=BOTTOM; all pulses 0; pre_beat_cnt=0.
  - restart takes priority over every other input in the same cycle.
- Beat detect:
  - pre_beat_cnt registers beat_cnt every cycle, including while frozen.
  - beat_add = (beat_cnt > pre_beat_cnt), unsigned compare.
  - A wrap to a smaller value is not a beat.
  - No spawn backlog accumulates during a freeze.
- Step: step = level+1, so level 0..3 gives 1..4 px per tick.
- Per-cycle order, evaluated on the pre-edge state when not frozen:
  1. Hit:
     - If key_press=1, select the valid slot with the largest block_h in [HIT_LO, HIT_HI]. Ties go to the lowest index.
     - The selected slot is invalidated and set to BOTTOM; hit_pulse=1 next cycle.
     - If no slot qualifies, there is no effect (no pulse).
     - At most one hit per cycle.
  2. Advance/miss, for every other valid slot:
     - If block_h+step >= BOTTOM: invalidate, set block_h=BOTTOM, and the slot contributes to miss_pulse (OR of all such slots).
     - Otherwise block_h += step.
     - Compute the sum at H_W+1 bits; there is no wrap.
  3. Spawn:
     - If beat_add & spawn_req: allocate the lowest-index slot that was invalid before this edge. That slot gets valid=1, block_h=TOP.
     - A slot freed in this same cycle is not reusable until the next cycle.
     - If no slot is free: overflow_pulse=1 and nothing changes.
- Latencies:
  - A spawned block is visible at TOP one cycle after the beat edge and first moves on the following edge.
  - All pulses are registered: high exactly one cycle, the cycle after the event.
- Hit vs miss on the same slot: the hit is evaluated on the current height before the advance, so a slot in the window with key_press is scored as a hit, never a miss.
- Freeze (stop_or_endgame=1):
  - heights and valid flags hold.
  - key_press, spawn_req and bottom detection are ignored; pulses are 0.
  - Resume continues from the held heights.
- Invalid slots always report block_h=BOTTOM.
- Heights never exceed BOTTOM.

Test Plan:
- Reset then single spawn:
  - Stimulus: rst pulse, level=0, beat_cnt 17→18 with spawn_req=1.
  - Response: next cycle valid[0]=1, h0=120. After 600 further ticks, h0 reaches 720, valid[0] drops, and miss_pulse is high for one cycle.
- Speed and boundary:
  - Stimulus: level=3 (step=4), h0=716.
  - Response: next edge retires the slot with h0=720 and miss_pulse. With h0=715, h0 becomes 719 and the slot stays valid.
- Hit window and priority:
  - Stimulus: slot0=650, slot1=610, key_press.
  - Response: slot0 retired, hit_pulse=1, slot1 advances.
  - Stimulus: key_press with slot at 599 or 681.
  - Response: no hit, slot advances.
- Overflow and slot reuse:
  - Stimulus: 4 live blocks, then a fifth spawn beat.
  - Response: overflow_pulse=1, states unchanged.
  - Stimulus: a spawn on the same edge a slot misses.
  - Response: overflow_pulse=1; the next spawn takes the freed lowest index.
- Freeze and beat wrap:
  - Stimulus: stop_or_endgame=1 for 10 ticks while beat_cnt 18→19 with spawn_req=1.
  - Response: heights hold, no spawn, no pulses. After release, no delayed spawn occurs.
  - Stimulus: beat_cnt 84→0.
  - Response: no spawn.
- Restart mid-game:
  - Stimulus: restart with 3 live blocks, key_press and spawn beat in the same cycle.
  - Response: all invalid, all heights 720, no pulses next cycle.

Source files
------------

// File: rtl/lane_block_tracker.sv
// Falling-block tracker for one piano lane: spawns blocks on qualifying beats,
// advances them at a level-dependent speed, and scores hits and misses.
module lane_block_tracker #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned H_W       = 10,
  parameter int unsigned BEAT_W    = 7,
  parameter int unsigned TOP       = 120,
  parameter int unsigned BOTTOM    = 720,
  parameter int unsigned HIT_LO    = 600,
  parameter int unsigned HIT_HI    = 680
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     restart,
  input  logic                     stop_or_endgame,
  input  logic [1:0]               level,
  input  logic [BEAT_W-1:0]        beat_cnt,
  input  logic                     spawn_req,
  input  logic                     key_press,
  output logic [NUM_SLOTS*H_W-1:0] block_h,
  output logic [NUM_SLOTS-1:0]     block_valid,
  output logic                     hit_pulse,
  output logic                     miss_pulse,
  output logic                     overflow_pulse
);

  localparam int unsigned SUM_W = H_W + 1;

  localparam logic [H_W-1:0]   TOP_H    = H_W'(TOP);
  localparam logic [H_W-1:0]   BOTTOM_H = H_W'(BOTTOM);
  localparam logic [H_W-1:0]   HIT_LO_H = H_W'(HIT_LO);
  localparam logic [H_W-1:0]   HIT_HI_H = H_W'(HIT_HI);
  localparam logic [SUM_W-1:0] BOTTOM_S = SUM_W'(BOTTOM);

  logic [H_W-1:0]    h_q [NUM_SLOTS];
  logic [H_W-1:0]    h_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [BEAT_W-1:0] pre_beat_q, pre_beat_d;
  logic              hit_pulse_q, hit_pulse_d;
  logic              miss_pulse_q, miss_pulse_d;
  logic              overflow_pulse_q, overflow_pulse_d;

  logic                 beat_add;
  logic [SUM_W-1:0]     step;
  logic [SUM_W-1:0]     sum;
  logic                 hit_found;
  logic [H_W-1:0]       best_h;
  logic [NUM_SLOTS-1:0] hit_sel;
  logic                 spawn_done;

  assign beat_add = (beat_cnt > pre_beat_q);
  assign step     = SUM_W'(level) + SUM_W'(1);

  always_comb begin
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      h_d[i] = h_q[i];
    end
    valid_d          = valid_q;
    pre_beat_d       = beat_cnt;
    hit_pulse_d      = 1'b0;
    miss_pulse_d     = 1'b0;
    overflow_pulse_d = 1'b0;
    sum              = '0;
    hit_found        = 1'b0;
    best_h           = '0;
    hit_sel          = '0;
    spawn_done       = 1'b0;

    if (restart) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        h_d[i] = BOTTOM_H;
      end
      valid_d    = '0;
      pre_beat_d = '0;
    end else if (!stop_or_endgame) begin
      // Hit: lowest block in the window wins; strict compare keeps ties at the lowest index
      if (key_press) begin
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
          if (valid_q[i] && (h_q[i] >= HIT_LO_H) && (h_q[i] <= HIT_HI_H) &&
              (!hit_found || (h_q[i] > best_h))) begin
            hit_found  = 1'b1;
            best_h     = h_q[i];
            hit_sel    = '0;
            hit_sel[i] = 1'b1;
          end
        end
      end
      hit_pulse_d = hit_found;

      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        if (valid_q[i]) begin
          if (hit_sel[i]) begin
            valid_d[i] = 1'b0;
            h_d[i]     = BOTTOM_H;
          end else begin
            sum = {1'b0, h_q[i]} + step;
            if (sum >= BOTTOM_S) begin
              valid_d[i]   = 1'b0;
              h_d[i]       = BOTTOM_H;
              miss_pulse_d = 1'b1;
            end else begin
              h_d[i] = sum[H_W-1:0];
            end
          end
        end
      end

      // Spawn only into slots that were already free before this edge
      if (beat_add && spawn_req) begin
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
          if (!valid_q[i] && !spawn_done) begin
            spawn_done = 1'b1;
            valid_d[i] = 1'b1;
            h_d[i]     = TOP_H;
          end
        end
        overflow_pulse_d = !spawn_done;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        h_q[i] <= BOTTOM_H;
      end
      valid_q          <= '0;
      pre_beat_q       <= '0;
      hit_pulse_q      <= 1'b0;
      miss_pulse_q     <= 1'b0;
      overflow_pulse_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        h_q[i] <= h_d[i];
      end
      valid_q          <= valid_d;
      pre_beat_q       <= pre_beat_d;
      hit_pulse_q      <= hit_pulse_d;
      miss_pulse_q     <= miss_pulse_d;
      overflow_pulse_q <= overflow_pulse_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_SLOTS); g++) begin : g_pack
    assign block_h[g*H_W +: H_W] = h_q[g];
  end

  assign block_valid    = valid_q;
  assign hit_pulse      = hit_pulse_q;
  assign miss_pulse     = miss_pulse_q;
  assign overflow_pulse = overflow_pulse_q;

endmodule
